delay_var_vld: RTL and testbench



---
 rtl/delay_pkg.sv | 21 ++
 rtl/delay_tap_mux.sv | 28 ++
 rtl/delay_var_vld.sv | 153 +++++++++++++++
 tb/tb_delay_var_vld.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/delay_pkg.sv
// Shared types and helpers for the variable-tap valid-tagged delay line.
package delay_pkg;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_REFILL = 1'b1
  } state_e;

  // Width of a select port able to express 0..max_n.
  function automatic int unsigned sel_width(input int unsigned max_n);
    return $clog2(max_n + 1);
  endfunction

  // Map a requested delay onto the legal range 1..max_n.
  function automatic int unsigned sel_clamp(input int unsigned sel, input int unsigned max_n);
    if (sel == 0) return 1;
    if (sel > max_n) return max_n;
    return sel;
  endfunction

endpackage

// File: rtl/delay_tap_mux.sv
// Combinational tap select: returns {vld, data} of stage sel-1 (sel is 1..MAX_N).
module delay_tap_mux
  import delay_pkg::*;
#(
  parameter int unsigned MAX_N = 8,
  parameter int unsigned BITS  = 8,
  parameter int unsigned SEL_W = sel_width(MAX_N)
) (
  input  logic [SEL_W-1:0]           sel,
  input  logic [MAX_N-1:0]           vld,
  input  logic [MAX_N-1:0][BITS-1:0] data,
  output logic                       vld_c,
  output logic [BITS-1:0]            q_c
);

  // Compare-based select keeps index widths independent of SEL_W.
  always_comb begin
    vld_c = 1'b0;
    q_c   = '0;
    for (int k = 0; k < int'(MAX_N); k++) begin
      if (sel == SEL_W'(k + 1)) begin
        vld_c = vld[k];
        q_c   = data[k];
      end
    end
  end

endmodule

// File: rtl/delay_var_vld.sv
// Runtime-selectable delay line carrying data plus per-stage valid, with flush.
// Build option DELAY_SEL_FLUSH_EN: a delay change flushes and suppresses output until refilled.
module delay_var_vld
  import delay_pkg::*;
#(
  parameter int unsigned    MAX_N = 8,
  parameter int unsigned    BITS  = 8,
  parameter logic [BITS-1:0] INIT = '0,
  parameter int unsigned    SEL_W = sel_width(MAX_N)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_flush,
  input  logic [SEL_W-1:0] i_sel,
  input  logic             i_vld,
  input  logic [BITS-1:0]  i_d,
  output logic             o_vld,
  output logic [BITS-1:0]  o_q,
  output logic             o_busy,
  output logic [SEL_W-1:0] o_occ
);

  logic [MAX_N-1:0][BITS-1:0] data_q;
  logic [MAX_N-1:0]           vld_q;
  logic [MAX_N-1:0]           vld_nxt;
  logic [SEL_W-1:0]           sel_d;
  logic [SEL_W-1:0]           sel_q;
  logic [SEL_W-1:0]           occ_q;
  logic [SEL_W-1:0]           occ_nxt;
  logic                       busy_q;
  logic                       eff_flush;
  logic                       tap_vld;

  assign sel_d = SEL_W'(sel_clamp(32'(i_sel), MAX_N));

  always_comb begin
    vld_nxt    = vld_q;
    vld_nxt[0] = i_vld;
    for (int k = 1; k < int'(MAX_N); k++) vld_nxt[k] = vld_q[k-1];
  end

  // Occupancy tracks valids entering stage 0 versus leaving the last stage.
  always_comb begin
    occ_nxt = occ_q;
    if (eff_flush) begin
      occ_nxt = '0;
    end else if (i_en) begin
      case ({i_vld, vld_q[MAX_N-1]})
        2'b10:   occ_nxt = occ_q + SEL_W'(1);
        2'b01:   occ_nxt = occ_q - SEL_W'(1);
        default: occ_nxt = occ_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_q <= {MAX_N{INIT}};
      vld_q  <= '0;
      sel_q  <= SEL_W'(1);
      occ_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      sel_q  <= sel_d;
      occ_q  <= occ_nxt;
      busy_q <= (occ_nxt != '0);
      if (i_en) begin
        data_q[0] <= i_d;
        for (int k = 1; k < int'(MAX_N); k++) data_q[k] <= data_q[k-1];
      end
      if (eff_flush) vld_q <= '0;
      else if (i_en) vld_q <= vld_nxt;
    end
  end

  delay_tap_mux #(
    .MAX_N (MAX_N),
    .BITS  (BITS),
    .SEL_W (SEL_W)
  ) u_tap (
    .sel   (sel_q),
    .vld   (vld_q),
    .data  (data_q),
    .vld_c (tap_vld),
    .q_c   (o_q)
  );

  assign o_occ  = occ_q;
  assign o_busy = busy_q;

`ifdef DELAY_SEL_FLUSH_EN
  state_e           state_q;
  state_e           state_nxt;
  logic [SEL_W-1:0] cnt_q;
  logic [SEL_W-1:0] cnt_nxt;
  logic             sel_chg;
  logic             refill_c;

  assign sel_chg = (sel_d != sel_q);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  // Refill lasts until the new depth has been traversed by enabled edges.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (sel_chg) begin
          state_nxt = ST_REFILL;
          cnt_nxt   = '0;
        end
      end
      ST_REFILL: begin
        if (sel_chg) begin
          cnt_nxt = '0;
        end else if (i_en) begin
          if ((cnt_q + SEL_W'(1)) >= sel_q) begin
            state_nxt = ST_RUN;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_q + SEL_W'(1);
          end
        end
      end
      default: begin
        state_nxt = ST_RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    refill_c = (state_q == ST_REFILL);
  end

  assign eff_flush = i_flush | sel_chg;
  assign o_vld     = tap_vld & ~refill_c;
`else
  assign eff_flush = i_flush;
  assign o_vld     = tap_vld;
`endif

endmodule

// File: tb/tb_delay_var_vld.sv
// Directed bench for delay_var_vld (MAX_N=8, BITS=8, INIT=0).
module tb_delay_var_vld;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_en;
  logic       i_flush;
  logic [3:0] i_sel;
  logic       i_vld;
  logic [7:0] i_d;
  logic       o_vld;
  logic [7:0] o_q;
  logic       o_busy;
  logic [3:0] o_occ;

  int total = 0;
  int bad   = 0;

  delay_var_vld #(.MAX_N(8), .BITS(8)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (i_en),
    .i_flush (i_flush),
    .i_sel   (i_sel),
    .i_vld   (i_vld),
    .i_d     (i_d),
    .o_vld   (o_vld),
    .o_q     (o_q),
    .o_busy  (o_busy),
    .o_occ   (o_occ)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One valid 0xA5 sample; it must surface exactly exp_d enabled edges later.
  task automatic lat(input logic [3:0] sel, input int exp_d);
    i_flush = 1'b1; i_sel = sel; i_vld = 1'b0; i_en = 1'b1;
    step();
    i_flush = 1'b0; i_vld = 1'b1; i_d = 8'hA5;
    step();
    i_vld = 1'b0; i_d = 8'h00;
    for (int k = 1; k <= exp_d; k++) begin
      if (k < exp_d) begin
        chk($sformatf("lat%0d_early%0d", sel, k), 32'(o_vld), 32'd0);
        step();
      end else begin
        chk($sformatf("lat%0d_vld", sel), 32'(o_vld), 32'd1);
        chk($sformatf("lat%0d_q", sel), 32'(o_q), 32'hA5);
      end
    end
    step();
    chk($sformatf("lat%0d_gone", sel), 32'(o_vld), 32'd0);
  endtask

  initial begin
    int seen;
    i_rst_n = 1'b0; i_en = 1'b0; i_flush = 1'b0; i_sel = 4'd1; i_vld = 1'b0; i_d = 8'h00;
    step(); step();
    chk("rst_vld", 32'(o_vld), 32'd0);
    chk("rst_q", 32'(o_q), 32'd0);
    chk("rst_occ", 32'(o_occ), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    i_rst_n = 1'b1;

    // Load state, then assert reset between edges.
    i_en = 1'b1; i_vld = 1'b1; i_d = 8'h55;
    step(); step();
    chk("pre_vld", 32'(o_vld), 32'd1);
    chk("pre_q", 32'(o_q), 32'h55);
    chk("pre_occ", 32'(o_occ), 32'd2);
    #2 i_rst_n = 1'b0;
    #1;
    chk("async_vld", 32'(o_vld), 32'd0);
    chk("async_q", 32'(o_q), 32'd0);
    chk("async_occ", 32'(o_occ), 32'd0);
    chk("async_busy", 32'(o_busy), 32'd0);
    #1 i_rst_n = 1'b1;
    i_vld = 1'b0; i_d = 8'h00;

    lat(4'd3, 3);
    lat(4'd1, 1);
    lat(4'd8, 8);
    lat(4'd0, 1);
    lat(4'd12, 8);

    // Enable stall: pattern 1,0,0,1,1,1.
    i_flush = 1'b1; i_sel = 4'd4; i_en = 1'b1;
    step();
    i_flush = 1'b0; i_vld = 1'b1; i_d = 8'h3C;
    step();
    i_vld = 1'b0; i_d = 8'h00; i_en = 1'b0;
    step();
    chk("stall1_vld", 32'(o_vld), 32'd0);
    step();
    chk("stall2_occ", 32'(o_occ), 32'd1);
    i_en = 1'b1;
    step(); step();
    chk("stall_en3_vld", 32'(o_vld), 32'd0);
    step();
    chk("stall_out_vld", 32'(o_vld), 32'd1);
    chk("stall_out_q", 32'(o_q), 32'h3C);
    i_en = 1'b0;
    step();
    chk("stall_hold_vld", 32'(o_vld), 32'd1);
    chk("stall_hold_q", 32'(o_q), 32'h3C);

    // Flush with a simultaneous valid input.
    i_en = 1'b1; i_flush = 1'b1; i_sel = 4'd8;
    step();
    i_flush = 1'b0; i_vld = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      i_d = 8'(k);
      step();
    end
    chk("fill_occ", 32'(o_occ), 32'd5);
    chk("fill_busy", 32'(o_busy), 32'd1);
    i_flush = 1'b1; i_d = 8'h77;
    step();
    chk("flush_occ", 32'(o_occ), 32'd0);
    chk("flush_busy", 32'(o_busy), 32'd0);
    i_flush = 1'b0; i_vld = 1'b0; i_d = 8'h00;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (o_vld !== 1'b0) seen++;
    end
    chk("flush_no_emerge", 32'(seen), 32'd0);

    // Occupancy saturates at MAX_N.
    i_vld = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      i_d = 8'(k);
      step();
      if (k == 3) chk("sat_occ3", 32'(o_occ), 32'd3);
      if (k == 8) chk("sat_occ8", 32'(o_occ), 32'd8);
    end
    chk("sat_occ20", 32'(o_occ), 32'd8);
    chk("sat_q20", 32'(o_q), 32'd13);
    i_en = 1'b0; i_flush = 1'b1;
    step();
    chk("flush_noen_occ", 32'(o_occ), 32'd0);
    chk("flush_noen_busy", 32'(o_busy), 32'd0);

    // Delay change 6 -> 2 under an incrementing stream.
    i_flush = 1'b0; i_en = 1'b1; i_sel = 4'd6; i_vld = 1'b0;
    step();
    i_vld = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      i_d = 8'(k);
      step();
    end
    chk("d6_q", 32'(o_q), 32'd5);
    i_sel = 4'd2; i_d = 8'd11;
    step();
`ifdef DELAY_SEL_FLUSH_EN
    chk("chg_vld_a", 32'(o_vld), 32'd0);
    i_d = 8'd12;
    step();
    chk("chg_vld_b", 32'(o_vld), 32'd0);
    i_d = 8'd13;
    step();
    chk("chg_resume_vld", 32'(o_vld), 32'd1);
    chk("chg_resume_q", 32'(o_q), 32'd12);
    i_d = 8'd14;
    step();
    chk("chg_next_q", 32'(o_q), 32'd13);
`else
    chk("chg_vld", 32'(o_vld), 32'd1);
    chk("chg_skip_q", 32'(o_q), 32'd10);
    i_d = 8'd12;
    step();
    chk("chg_next_q", 32'(o_q), 32'd11);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
